// File: rtl/fw_scoreboard.sv
// Forwarding and hazard scoreboard for the dual-issue SPU pipes.
// Ports: clk, rst, flush, issue_* (bundle), src_addr/src_rf (RF read),
//   stage_data (per-stage result buses) -> src_fw, stall, stall_cnt.
module fw_scoreboard #(
  parameter int NUM_PIPES   = 2,
  parameter int NUM_SRC     = 3,
  parameter int DEPTH       = 7,
  parameter int REG_ADDR_WD = 7,
  parameter int REG_DATA_WD = 128
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush,
  input  logic [NUM_PIPES-1:0]                       issue_vld,
  input  logic [NUM_PIPES-1:0]                       issue_wr,
  input  logic [NUM_PIPES*REG_ADDR_WD-1:0]           issue_rt,
  input  logic [NUM_PIPES*3-1:0]                     issue_lat,
  input  logic [NUM_PIPES*NUM_SRC*REG_ADDR_WD-1:0]   src_addr,
  input  logic [NUM_PIPES*NUM_SRC*REG_DATA_WD-1:0]   src_rf,
  input  logic [NUM_PIPES*DEPTH*REG_DATA_WD-1:0]     stage_data,
  output logic [NUM_PIPES*NUM_SRC*REG_DATA_WD-1:0]   src_fw,
  output logic                                       stall,
  output logic [31:0]                                stall_cnt
);

  localparam int AW = REG_ADDR_WD;
  localparam int DW = REG_DATA_WD;

  // Index [p][s] holds stage s+1 of pipe p.
  logic [NUM_PIPES-1:0][DEPTH-1:0]         vld_q;
  logic [NUM_PIPES-1:0][DEPTH-1:0]         wr_q;
  logic [NUM_PIPES-1:0][DEPTH-1:0][AW-1:0] addr_q;
  logic [NUM_PIPES-1:0][DEPTH-1:0][2:0]    lat_q;

  logic    hit;
  logic    rdy;
  int      hq;
  int      hs;

  function automatic logic [2:0] clamp_lat(input logic [2:0] l);
    if (l == 3'd0)
      return 3'd1;
    else if (int'(l) > DEPTH)
      return 3'(DEPTH);
    else
      return l;
  endfunction

  // Scan oldest to youngest so the last hit is the youngest producer:
  // stages descending, and within a stage the higher pipe overrides.
  always_comb begin
    stall  = 1'b0;
    src_fw = src_rf;
    hit    = 1'b0;
    rdy    = 1'b0;
    hq     = 0;
    hs     = 0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        hit = 1'b0;
        rdy = 1'b0;
        hq  = 0;
        hs  = 0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
          for (int q = 0; q < NUM_PIPES; q++) begin
            if (vld_q[q][s] && wr_q[q][s] &&
                addr_q[q][s] == src_addr[(p*NUM_SRC+k)*AW +: AW]) begin
              hit = 1'b1;
              rdy = (s + 1) >= int'(lat_q[q][s]);
              hq  = q;
              hs  = s;
            end
          end
        end
        // A not-ready youngest match blocks any older ready value.
        if (hit && rdy)
          src_fw[(p*NUM_SRC+k)*DW +: DW] =
            stage_data[(hq*DEPTH+hs)*DW +: DW];
        if (hit && !rdy && issue_vld[p])
          stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      wr_q      <= '0;
      addr_q    <= '0;
      lat_q     <= '0;
      stall_cnt <= '0;
    end else begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        for (int s = DEPTH - 1; s >= 1; s--) begin
          vld_q[p][s]  <= vld_q[p][s-1];
          wr_q[p][s]   <= wr_q[p][s-1];
          addr_q[p][s] <= addr_q[p][s-1];
          lat_q[p][s]  <= lat_q[p][s-1];
        end
        vld_q[p][0]  <= issue_vld[p] && !stall;
        wr_q[p][0]   <= issue_wr[p];
        addr_q[p][0] <= issue_rt[p*AW +: AW];
        lat_q[p][0]  <= clamp_lat(issue_lat[p*3 +: 3]);
      end
      if (flush)
        vld_q <= '0;
      if (stall && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fw_scoreboard.sv
// Directed bench for fw_scoreboard.
// Drives bundles after posedge and checks combinational/registered outputs.
module tb_fw_scoreboard;

  localparam int NP = 2;
  localparam int NS = 3;
  localparam int D  = 7;
  localparam int AW = 7;
  localparam int DW = 128;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic [NP-1:0]        issue_vld;
  logic [NP-1:0]        issue_wr;
  logic [NP*AW-1:0]     issue_rt;
  logic [NP*3-1:0]      issue_lat;
  logic [NP*NS*AW-1:0]  src_addr;
  logic [NP*NS*DW-1:0]  src_rf;
  logic [NP*D*DW-1:0]   stage_data;
  logic [NP*NS*DW-1:0]  src_fw;
  logic                 stall;
  logic [31:0]          stall_cnt;

  logic [AW-1:0] rt [NP];
  logic [2:0]    lt [NP];
  logic [AW-1:0] sa [NP][NS];
  logic [DW-1:0] rf [NP][NS];
  logic [DW-1:0] sd [NP][D];
  logic [DW-1:0] fw [NP][NS];

  int checks;
  int errors;

  localparam logic [DW-1:0] AA = {16{8'hAA}};

  fw_scoreboard #(
    .NUM_PIPES(NP), .NUM_SRC(NS), .DEPTH(D),
    .REG_ADDR_WD(AW), .REG_DATA_WD(DW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_vld(issue_vld), .issue_wr(issue_wr),
    .issue_rt(issue_rt), .issue_lat(issue_lat),
    .src_addr(src_addr), .src_rf(src_rf),
    .stage_data(stage_data), .src_fw(src_fw),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    issue_rt   = '0;
    issue_lat  = '0;
    src_addr   = '0;
    src_rf     = '0;
    stage_data = '0;
    for (int p = 0; p < NP; p++) begin
      issue_rt[p*AW +: AW] = rt[p];
      issue_lat[p*3 +: 3]  = lt[p];
      for (int k = 0; k < NS; k++) begin
        src_addr[(p*NS+k)*AW +: AW] = sa[p][k];
        src_rf[(p*NS+k)*DW +: DW]   = rf[p][k];
      end
      for (int s = 0; s < D; s++)
        stage_data[(p*D+s)*DW +: DW] = sd[p][s];
    end
  end

  always_comb begin
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < NS; k++)
        fw[p][k] = src_fw[(p*NS+k)*DW +: DW];
  end

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush     = 1'b0;
    issue_vld = '0;
    issue_wr  = '0;
    for (int p = 0; p < NP; p++) begin
      rt[p] = 7'd99;
      lt[p] = 3'd1;
      for (int k = 0; k < NS; k++) begin
        sa[p][k] = 7'd100;
        rf[p][k] = AA;
      end
    end
  endtask

  task automatic drain();
    idle();
    repeat (D + 1) clk_step();
  endtask

  task automatic test_reset();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < NS; k++)
        sa[p][k] = 7'd5;
    #1;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < NS; k++) begin
        checks++;
        if (fw[p][k] !== AA) begin
          $display("FAIL reset_fw p%0d k%0d: got %h want %h",
                   p, k, fw[p][k], AA);
          errors++;
        end
      end
    checks++;
    if (stall !== 1'b0) begin
      $display("FAIL reset_stall: got %b want 0", stall);
      errors++;
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
      errors++;
    end
    idle();
  endtask

  task automatic test_single_hazard();
    issue_vld = 2'b01;
    issue_wr  = 2'b01;
    rt[0]     = 7'd10;
    lt[0]     = 3'd2;
    clk_step();
    issue_wr  = 2'b00;
    sa[0][0]  = 7'd10;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      $display("FAIL hz1_stall: got %b want 1", stall);
      errors++;
    end
    clk_step();
    checks++;
    if (stall !== 1'b0) begin
      $display("FAIL hz1_release: got %b want 0", stall);
      errors++;
    end
    checks++;
    if (fw[0][0] !== sd[0][1]) begin
      $display("FAIL hz1_fw: got %h want %h", fw[0][0], sd[0][1]);
      errors++;
    end
    checks++;
    if (stall_cnt !== 32'd1) begin
      $display("FAIL hz1_cnt: got %0d want 1", stall_cnt);
      errors++;
    end
    clk_step();
    drain();
  endtask

  task automatic test_youngest_not_ready();
    issue_vld = 2'b01;
    issue_wr  = 2'b01;
    rt[0]     = 7'd10;
    lt[0]     = 3'd2;
    clk_step();
    idle();
    clk_step();
    clk_step();
    issue_vld = 2'b01;
    issue_wr  = 2'b01;
    rt[0]     = 7'd10;
    lt[0]     = 3'd6;
    clk_step();
    issue_wr  = 2'b00;
    rt[0]     = 7'd99;
    sa[0][0]  = 7'd10;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      $display("FAIL yng_stall0: got %b want 1", stall);
      errors++;
    end
    checks++;
    if (fw[0][0] === sd[0][3]) begin
      $display("FAIL yng_old_fw: got %h must differ from %h",
               fw[0][0], sd[0][3]);
      errors++;
    end
    for (int i = 0; i < 4; i++) begin
      clk_step();
      checks++;
      if (stall !== 1'b1) begin
        $display("FAIL yng_stall%0d: got %b want 1", i + 1, stall);
        errors++;
      end
    end
    clk_step();
    checks++;
    if (stall !== 1'b0) begin
      $display("FAIL yng_release: got %b want 0", stall);
      errors++;
    end
    checks++;
    if (fw[0][0] !== sd[0][5]) begin
      $display("FAIL yng_fw: got %h want %h", fw[0][0], sd[0][5]);
      errors++;
    end
    checks++;
    if (stall_cnt !== 32'd6) begin
      $display("FAIL yng_cnt: got %0d want 6", stall_cnt);
      errors++;
    end
    clk_step();
    drain();
  endtask

  task automatic test_same_stage();
    issue_vld = 2'b11;
    issue_wr  = 2'b11;
    rt[0]     = 7'd3;
    rt[1]     = 7'd3;
    lt[0]     = 3'd1;
    lt[1]     = 3'd0;
    clk_step();
    idle();
    issue_vld = 2'b11;
    sa[0][1]  = 7'd3;
    sa[1][2]  = 7'd3;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      $display("FAIL same_stall: got %b want 0", stall);
      errors++;
    end
    checks++;
    if (fw[0][1] !== sd[1][0]) begin
      $display("FAIL same_fw01: got %h want %h", fw[0][1], sd[1][0]);
      errors++;
    end
    checks++;
    if (fw[1][2] !== sd[1][0]) begin
      $display("FAIL same_fw12: got %h want %h", fw[1][2], sd[1][0]);
      errors++;
    end
    checks++;
    if (fw[0][0] !== AA) begin
      $display("FAIL same_nomatch: got %h want %h", fw[0][0], AA);
      errors++;
    end
    clk_step();
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      issue_vld = 2'b01;
      issue_wr  = 2'b01;
      rt[0]     = 7'd7;
      lt[0]     = 3'd7;
      clk_step();
    end
    flush    = 1'b1;
    sa[0][0] = 7'd7;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      $display("FAIL flush_pre_stall: got %b want 1", stall);
      errors++;
    end
    clk_step();
    flush    = 1'b0;
    issue_wr = 2'b00;
    rf[0][0] = {16{8'h77}};
    #1;
    checks++;
    if (stall !== 1'b0) begin
      $display("FAIL flush_stall: got %b want 0", stall);
      errors++;
    end
    checks++;
    if (fw[0][0] !== {16{8'h77}}) begin
      $display("FAIL flush_fw: got %h want %h", fw[0][0], {16{8'h77}});
      errors++;
    end
    checks++;
    if (stall_cnt !== 32'd7) begin
      $display("FAIL flush_cnt: got %0d want 7", stall_cnt);
      errors++;
    end
    clk_step();
    drain();
  endtask

  task automatic test_saturate_and_reset();
    issue_vld = 2'b01;
    issue_wr  = 2'b01;
    rt[0]     = 7'd20;
    lt[0]     = 3'd7;
    clk_step();
    issue_wr  = 2'b00;
    rt[0]     = 7'd99;
    sa[0][0]  = 7'd20;
    @(negedge clk);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    clk_step();
    checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      $display("FAIL sat_reach: got %h want ffffffff", stall_cnt);
      errors++;
    end
    clk_step();
    checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      $display("FAIL sat_hold: got %h want ffffffff", stall_cnt);
      errors++;
    end
    checks++;
    if (stall !== 1'b1) begin
      $display("FAIL sat_stall: got %b want 1", stall);
      errors++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (stall_cnt !== 32'd0) begin
      $display("FAIL arst_cnt: got %h want 0", stall_cnt);
      errors++;
    end
    checks++;
    if (stall !== 1'b0) begin
      $display("FAIL arst_stall: got %b want 0", stall);
      errors++;
    end
    checks++;
    if (fw[0][0] !== AA) begin
      $display("FAIL arst_fw: got %h want %h", fw[0][0], AA);
      errors++;
    end
    #4;
    rst = 1'b0;
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < D; s++)
        sd[p][s] = DW'((p + 1) * 256 + s + 1);
    #12;
    rst = 1'b0;
    test_reset();
    test_single_hazard();
    test_youngest_not_ready();
    test_same_stage();
    test_flush();
    test_saturate_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
